sha256_block_sequencer: RTL and testbench
=========================================

# sha256_block_sequencer

Multi-block message controller for the `sha256` compression core. It accepts pre-padded 512-bit message blocks over a valid/ready stream. It issues one `input_valid` pulse per block to the core and waits for the core's `output_valid`. It chains each `H_out` into the next block's `H_in` and presents the final 256-bit digest on a held-until-accepted output. It sits between the Hash160 front-end (padding/packing) and the RIPEMD160 stage, so that messages longer than 55 bytes can be hashed.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles from the core start pulse to `output_valid` before a hang is declared. Also the post-reset flush length.
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `blk_valid`  in  1  `blk_data`/`blk_last` are valid.
- `blk_ready`  out  1  sequencer accepts a block this cycle.
- `blk_data`  in  512  padded message block, big-endian word order as the core expects.
- `blk_last`  in  1  block is the final block of the message.
- `digest_valid`  out  1  `digest` is valid; held until accepted.
- `digest_ready`  in  1  consumer accepts the digest.
- `digest`  out  256  final chained hash value.
- `busy`  out  1  high in every state except S_ACCEPT with no message in progress.
- `error`  out  1  sticky core-timeout flag; cleared only by `rst`.
- `block_count`  out  16  blocks completed in the current message; saturates at 16'hFFFF.

## Operation
- The block contains one instance each of `sha256` and `sha256_H_0`.
- Core connections:
  - `M_in` is driven from `m_reg`.
  - `H_in` is driven from `h_reg`.
  - `m_reg` and `h_reg` are held stable from the start pulse until `output_valid`.
- FSM states: S_FLUSH, S_ACCEPT, S_START, S_WAIT, S_DONE, S_ERR.
- S_FLUSH (entered on reset):
  - `blk_ready`=0.
  - Counts `TIMEOUT_CYCLES` cycles, then moves to S_ACCEPT.
  - Core `output_valid` is ignored, so a stale result from a pre-reset computation is drained.
- S_ACCEPT:
  - `blk_ready`=1.
  - On `blk_valid`&&`blk_ready`: `m_reg`<=`blk_data`, `last_reg`<=`blk_last`, next state S_START.
- S_START:
  - Core `input_valid`=1 for exactly this one cycle.
  - Timer cleared; next state S_WAIT.
- S_WAIT:
  - Timer increments each cycle.
  - On core `output_valid`: `h_reg`<=`H_out`; `block_count`+1 (saturating).
    - If `last_reg`=1, go to S_DONE; otherwise go to S_ACCEPT.
  - If the timer reaches `TIMEOUT_CYCLES` and `output_valid` is not asserted in that same cycle: go to S_ERR, `error`<=1.
  - `output_valid` wins over a simultaneous timeout.
- S_DONE:
  - `digest_valid`=1, `digest`=`h_reg`.
  - On `digest_ready`: `h_reg`<=H0, `block_count`<=0, next state S_ACCEPT.
- S_ERR:
  - `blk_ready`=0, `digest_valid`=0, `busy`=1.
  - Remains here until `rst`.
- Core `output_valid` outside S_WAIT is ignored.
- `h_reg` holds H0 at the start of every message, so the first block always compresses from the initial hash value.

## Timing
- Reset values:
  - `blk_ready`=0, `digest_valid`=0, `digest`=H0, `error`=0, `block_count`=0, `busy`=1.
  - State S_FLUSH, `h_reg`=H0, `m_reg`=0, core `input_valid`=0.
- Reset mid-operation restarts from S_FLUSH regardless of state. Any in-flight block or digest is discarded.
- Block accept to core start pulse: 1 cycle. Core `output_valid` to `blk_ready` for the next block: 1 cycle.
- Per-block overhead beyond core latency L: 2 cycles (START and the ACCEPT handshake). An N-block message completes in N·(L+2) cycles plus the digest handshake.
- `digest_valid` rises the cycle after the last `output_valid`. If `digest_ready` is already high, `digest_valid` is high for one cycle only.
- `digest` and `digest_valid` must not change while `digest_valid`=1 and `digest_ready`=0.

## Structure
- Shared package `sha256_pkg`:
  - SHA-256 H0 constant (256-bit).
  - State enum.
  - Block width (512) and digest width (256) constants.
  - `block_count` width constant.
- The `sha256` core plus `sha256_H_0` form the natural single sub-module. The sequencer adds only the FSM, the timer and the `m_reg`/`h_reg`/`block_count` registers.

## Test plan
- Single block "abc" (`blk_last`=1) -> `digest`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `block_count`=1, exactly one core `input_valid` pulse.
- Two blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", `blk_valid` deasserted 5 cycles between blocks -> `digest`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, `block_count`=2.
- Back-to-back messages with `digest_ready` held low 10 cycles -> `digest` stable throughout; second message's digest is correct (`h_reg` reset to H0 between messages).
- Stub core that never asserts `output_valid` -> `error`=1 exactly `TIMEOUT_CYCLES` cycles after the start pulse; `blk_ready` stays 0 until `rst`.
- `rst` asserted mid-S_WAIT, stale `output_valid` arriving during flush -> ignored. `blk_ready` returns after `TIMEOUT_CYCLES` cycles, and the next "abc" digest is correct.
- `blk_ready`=0 in every state except S_ACCEPT; a `blk_valid` pulse while busy is not consumed.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and SHA-256 helper functions for the
// multi-block sequencer and its compression core.
package sha256_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned COUNT_W  = 16;

  localparam logic [DIGEST_W-1:0] SHA256_H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_FLUSH,
    S_ACCEPT,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } seq_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256.sv
// Iterative SHA-256 compression core: one round per cycle, output_valid
// pulses 65 cycles after input_valid. The core has no reset input.
module sha256
  import sha256_pkg::*;
(
  input  logic                clk,
  input  logic                input_valid,
  input  logic [BLOCK_W-1:0]  M_in,
  input  logic [DIGEST_W-1:0] H_in,
  output logic                output_valid,
  output logic [DIGEST_W-1:0] H_out
);

  // Working variables a..h live in v_q[7]..v_q[0], matching H_in word order.
  logic [7:0][31:0]   v_q, v_d;
  logic [BLOCK_W-1:0] w_q, w_d;
  logic [5:0]         round_q;
  logic               active_q;
  logic               done_q;

  always_comb begin
    logic [31:0] t1, t2, ch, maj, wnext;
    ch    = (v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1]);
    maj   = (v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]);
    t1    = v_q[0] + bsig1(v_q[3]) + ch + SHA256_K[round_q] + w_q[511:480];
    t2    = bsig0(v_q[7]) + maj;
    v_d   = {t1 + t2, v_q[7], v_q[6], v_q[5], v_q[4] + t1, v_q[3], v_q[2], v_q[1]};
    wnext = ssig1(w_q[63:32]) + w_q[223:192] + ssig0(w_q[479:448]) + w_q[511:480];
    w_d   = {w_q[479:0], wnext};
  end

  always_ff @(posedge clk) begin
    if (input_valid) begin
      v_q      <= H_in;
      w_q      <= M_in;
      round_q  <= '0;
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      v_q     <= v_d;
      w_q     <= w_d;
      round_q <= round_q + 6'd1;
      if (round_q == 6'd63) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  // H_in is held stable by the caller, so the feed-forward add uses it directly.
  always_comb begin
    H_out = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      H_out[i*32 +: 32] = H_in[i*32 +: 32] + v_q[i];
    end
  end

  assign output_valid = done_q;

endmodule

// File: rtl/sha256_H_0.sv
// Source of the SHA-256 initial hash value H0.
module sha256_H_0
  import sha256_pkg::*;
(
  output logic [DIGEST_W-1:0] H_0
);

  assign H_0 = SHA256_H0;

endmodule

// File: rtl/sha256_block_sequencer_core.sv
// Compression core plus H0 source, bundled as the sequencer's datapath.
module sha256_block_sequencer_core
  import sha256_pkg::*;
(
  input  logic                clk_i,
  input  logic                start_i,
  input  logic [BLOCK_W-1:0]  m_i,
  input  logic [DIGEST_W-1:0] h_i,
  output logic                done_o,
  output logic [DIGEST_W-1:0] h_o,
  output logic [DIGEST_W-1:0] h0_o
);

  sha256 u_sha256 (
    .clk          (clk_i),
    .input_valid  (start_i),
    .M_in         (m_i),
    .H_in         (h_i),
    .output_valid (done_o),
    .H_out        (h_o)
  );

  sha256_H_0 u_h0 (
    .H_0 (h0_o)
  );

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds pre-padded 512-bit blocks to the SHA-256 core, chains H across the
// blocks of a message and holds the final digest until accepted.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [BLOCK_W-1:0]  blk_data,
  input  logic                blk_last,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                busy,
  output logic                error,
  output logic [COUNT_W-1:0]  block_count
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  seq_state_e          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [BLOCK_W-1:0]  m_q, m_d;
  logic [DIGEST_W-1:0] h_q, h_d;
  logic                last_q, last_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                core_start;
  logic                core_done;
  logic [DIGEST_W-1:0] core_h;
  logic [DIGEST_W-1:0] h0;

  sha256_block_sequencer_core u_core (
    .clk_i   (clk),
    .start_i (core_start),
    .m_i     (m_q),
    .h_i     (h_q),
    .done_o  (core_done),
    .h_o     (core_h),
    .h0_o    (h0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FLUSH;
      timer_q <= '0;
      m_q     <= '0;
      h_q     <= h0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      m_q     <= m_d;
      h_q     <= h_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    m_d     = m_q;
    h_d     = h_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      // The core cannot be reset, so any result still in flight is left to drain here.
      S_FLUSH: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (blk_valid) begin
          m_d     = blk_data;
          last_d  = blk_last;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (core_done) begin
          h_d     = core_h;
          if (cnt_q != '1) cnt_d = cnt_q + COUNT_W'(1);
          state_d = last_q ? S_DONE : S_ACCEPT;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        if (digest_ready) begin
          h_d     = h0;
          cnt_d   = '0;
          state_d = S_ACCEPT;
        end
      end
      S_ERR: ;
      default: state_d = S_FLUSH;
    endcase
  end

  assign core_start   = (state_q == S_START);
  assign blk_ready    = (state_q == S_ACCEPT);
  assign digest_valid = (state_q == S_DONE);
  assign digest       = h_q;
  assign busy         = !((state_q == S_ACCEPT) && (cnt_q == '0));
  assign error        = err_q;
  assign block_count  = cnt_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer using known SHA-256 test vectors.
module tb_sha256_block_sequencer;

  localparam int unsigned TMO   = 255;
  localparam int unsigned TMO_T = 20;
  localparam int unsigned LAT   = 66;

  localparam logic [255:0] H0_EXP    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_EXP   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] LONG_EXP  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] EMPTY_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_L1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_L2 = {{15{32'h0}}, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst, rst_t;
  logic         blk_valid, blk_last, blk_ready;
  logic [511:0] blk_data;
  logic         digest_valid, digest_ready, busy, error;
  logic [255:0] digest;
  logic [15:0]  block_count;

  logic         blk_valid_t, blk_last_t, blk_ready_t;
  logic [511:0] blk_data_t;
  logic         digest_valid_t, digest_ready_t, busy_t, error_t;
  logic [255:0] digest_t;
  logic [15:0]  block_count_t;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;

  always #5 clk = ~clk;

  sha256_block_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_last     (blk_last),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .digest       (digest),
    .busy         (busy),
    .error        (error),
    .block_count  (block_count)
  );

  sha256_block_sequencer #(.TIMEOUT_CYCLES(TMO_T)) dut_t (
    .clk          (clk),
    .rst          (rst_t),
    .blk_valid    (blk_valid_t),
    .blk_ready    (blk_ready_t),
    .blk_data     (blk_data_t),
    .blk_last     (blk_last_t),
    .digest_valid (digest_valid_t),
    .digest_ready (digest_ready_t),
    .digest       (digest_t),
    .busy         (busy_t),
    .error        (error_t),
    .block_count  (block_count_t)
  );

  always @(posedge clk) if (dut.core_start) starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_flush(output int n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!blk_ready && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic send_block(input logic [511:0] d, input logic l);
    int n;
    n = 0;
    blk_valid = 1'b1;
    blk_data  = d;
    blk_last  = l;
    while (!blk_ready && n < 1000) begin
      tick();
      n++;
    end
    vectors++;
    if (!blk_ready) begin
      miscompares++;
      $display("FAIL send_block: blk_ready=%0b after %0d cycles, required 1", blk_ready, n);
    end
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
  endtask

  task automatic wait_digest(output int n);
    n = 0;
    while (!digest_valid && n < 1000) begin
      n++;
      tick();
    end
    vectors++;
    if (!digest_valid) begin
      miscompares++;
      $display("FAIL wait_digest: digest_valid never rose in %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (blk_ready !== 1'b0 || digest_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: ready=%b dvalid=%b error=%b busy=%b, required 0 0 0 1",
               blk_ready, digest_valid, error, busy);
    end
    vectors++;
    if (digest !== H0_EXP || block_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_regs: digest=%h count=%0d, required %h 0", digest, block_count, H0_EXP);
    end
    reset_and_flush(n);
    vectors++;
    if (n != TMO) begin
      miscompares++;
      $display("FAIL flush_len: %0d cycles, required %0d", n, TMO);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_single_abc();
    int n, s0;
    digest_ready = 1'b1;
    s0 = starts;
    send_block(BLK_ABC, 1'b1);
    wait_digest(n);
    vectors++;
    if (n != LAT) begin
      miscompares++;
      $display("FAIL abc_latency: %0d cycles, required %0d", n, LAT);
    end
    vectors++;
    if (digest !== ABC_EXP) begin
      miscompares++;
      $display("FAIL abc_digest: got %h, required %h", digest, ABC_EXP);
    end
    vectors++;
    if (block_count !== 16'd1 || starts - s0 != 1) begin
      miscompares++;
      $display("FAIL abc_counts: block_count=%0d starts=%0d, required 1 1", block_count, starts - s0);
    end
    tick();
    vectors++;
    if (digest_valid !== 1'b0 || digest !== H0_EXP || block_count !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abc_release: dvalid=%b digest=%h count=%0d busy=%b, required 0 H0 0 0",
               digest_valid, digest, block_count, busy);
    end
  endtask

  task automatic test_two_block();
    int n;
    digest_ready = 1'b1;
    send_block(BLK_L1, 1'b0);
    n = 0;
    while (!blk_ready && n < 1000) begin
      n++;
      tick();
    end
    repeat (5) tick();
    vectors++;
    if (blk_ready !== 1'b1 || busy !== 1'b1 || block_count !== 16'd1) begin
      miscompares++;
      $display("FAIL mid_message: ready=%b busy=%b count=%0d, required 1 1 1", blk_ready, busy, block_count);
    end
    send_block(BLK_L2, 1'b1);
    wait_digest(n);
    vectors++;
    if (digest !== LONG_EXP || block_count !== 16'd2) begin
      miscompares++;
      $display("FAIL two_block: digest=%h count=%0d, required %h 2", digest, block_count, LONG_EXP);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, bad;
    digest_ready = 1'b0;
    send_block(BLK_ABC, 1'b1);
    wait_digest(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (digest_valid !== 1'b1 || digest !== ABC_EXP) bad++;
      tick();
    end
    vectors++;
    if (bad != 0 || digest_valid !== 1'b1 || digest !== ABC_EXP) begin
      miscompares++;
      $display("FAIL hold_stable: %0d unstable cycles, dvalid=%b digest=%h, required held %h",
               bad, digest_valid, digest, ABC_EXP);
    end
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    vectors++;
    if (digest_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: dvalid=%b, required 0", digest_valid);
    end
    send_block(BLK_EMPTY, 1'b1);
    wait_digest(n);
    vectors++;
    if (digest !== EMPTY_EXP || block_count !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_second: digest=%h count=%0d, required %h 1", digest, block_count, EMPTY_EXP);
    end
    digest_ready = 1'b1;
    tick();
  endtask

  task automatic test_busy_ignored();
    int n, bad, s0;
    digest_ready = 1'b1;
    s0 = starts;
    send_block(BLK_ABC, 1'b1);
    blk_valid = 1'b1;
    blk_data  = BLK_L1;
    blk_last  = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (blk_ready !== 1'b0) bad++;
      tick();
    end
    blk_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL busy_ready: blk_ready high in %0d busy cycles, required 0", bad);
    end
    wait_digest(n);
    vectors++;
    if (digest !== ABC_EXP || starts - s0 != 1) begin
      miscompares++;
      $display("FAIL busy_ignored: digest=%h starts=%0d, required %h 1", digest, starts - s0, ABC_EXP);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int n;
    digest_ready = 1'b1;
    send_block(BLK_ABC, 1'b1);
    repeat (30) tick();
    reset_and_flush(n);
    vectors++;
    if (n != TMO) begin
      miscompares++;
      $display("FAIL midreset_flush: %0d cycles, required %0d", n, TMO);
    end
    vectors++;
    if (digest !== H0_EXP || block_count !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_ignored: digest=%h count=%0d busy=%b, required H0 0 0", digest, block_count, busy);
    end
    send_block(BLK_ABC, 1'b1);
    wait_digest(n);
    vectors++;
    if (digest !== ABC_EXP || block_count !== 16'd1) begin
      miscompares++;
      $display("FAIL after_reset: digest=%h count=%0d, required %h 1", digest, block_count, ABC_EXP);
    end
    tick();
  endtask

  // Core latency exceeds TMO_T on this instance, which therefore looks hung.
  task automatic test_timeout();
    int n, bad;
    rst_t = 1'b1;
    tick();
    rst_t = 1'b0;
    n = 0;
    while (!blk_ready_t && n < 1000) begin
      n++;
      tick();
    end
    vectors++;
    if (n != TMO_T) begin
      miscompares++;
      $display("FAIL t_flush_len: %0d cycles, required %0d", n, TMO_T);
    end
    blk_valid_t = 1'b1;
    blk_data_t  = BLK_ABC;
    blk_last_t  = 1'b1;
    tick();
    blk_valid_t = 1'b0;
    for (int k = 1; k <= TMO_T; k++) tick();
    vectors++;
    if (error_t !== 1'b0) begin
      miscompares++;
      $display("FAIL t_early: error=%b at %0d cycles after start, required 0", error_t, TMO_T);
    end
    tick();
    vectors++;
    if (error_t !== 1'b1) begin
      miscompares++;
      $display("FAIL t_error: error=%b at %0d cycles after start, required 1", error_t, TMO_T + 1);
    end
    blk_valid_t = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (blk_ready_t !== 1'b0 || busy_t !== 1'b1 || digest_valid_t !== 1'b0 || error_t !== 1'b1) bad++;
      tick();
    end
    blk_valid_t = 1'b0;
    vectors++;
    if (bad != 0 || block_count_t !== 16'd0) begin
      miscompares++;
      $display("FAIL t_stuck: %0d bad cycles, count=%0d, required 0 0", bad, block_count_t);
    end
    rst_t = 1'b1;
    tick();
    rst_t = 1'b0;
    vectors++;
    if (error_t !== 1'b0 || blk_ready_t !== 1'b0) begin
      miscompares++;
      $display("FAIL t_clear: error=%b ready=%b, required 0 0", error_t, blk_ready_t);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_t = 1'b1;
    blk_valid = 1'b0;
    blk_last = 1'b0;
    blk_data = '0;
    digest_ready = 1'b0;
    blk_valid_t = 1'b0;
    blk_last_t = 1'b0;
    blk_data_t = '0;
    digest_ready_t = 1'b0;
    #1;
    test_reset();
    test_single_abc();
    test_two_block();
    test_back_to_back();
    test_busy_ignored();
    test_reset_mid_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
